// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, opcodes,
// ALU operation codes, mux select codes and R-type function bit positions.
package mc_cu_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXR  = 4'd2,
    S_WBR  = 4'd3,
    S_EXI  = 4'd4,
    S_WBI  = 4'd5,
    S_MA   = 4'd6,
    S_MR   = 4'd7,
    S_MW   = 4'd8,
    S_MWB  = 4'd9,
    S_JMP  = 4'd10,
    S_BR   = 4'd11,
    S_HALT = 4'd12,
    S_ERR  = 4'd13
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_STORE  = 4'b0001;
  localparam logic [3:0] OP_JUMP   = 4'b0010;
  localparam logic [3:0] OP_BRZ    = 4'b0100;
  localparam logic [3:0] OP_RTYPE  = 4'b1000;
  localparam logic [1:0] OP_IMM_HI = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam int FN_MOV0 = 0;
  localparam int FN_MOV1 = 1;
  localparam int FN_ADD  = 2;
  localparam int FN_SUB  = 3;
  localparam int FN_AND  = 4;
  localparam int FN_OR   = 5;
  localparam int FN_NOT  = 6;

  function automatic logic is_mem_wait(input state_t s);
    return (s == S_IF) || (s == S_MR) || (s == S_MW);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles of a memory state; o_hit flags that the
// count has reached TIMEOUT. The count saturates at TIMEOUT.
module mc_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_hit = (r_cnt == LIMIT);

endmodule

// File: rtl/mc_control_unit_p.sv
// Multi-cycle control unit FSM with mem_ready handshake, wait timeout, illegal
// opcode trap and HALT. Define MC_CU_PERF_EN to add cyc_cnt/instr_cnt counters.
module mc_control_unit_p
  import mc_cu_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int FUNC_W  = 9,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opc,
  input  logic [FUNC_W-1:0] func,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic              IorD,
  output logic              IRWrite,
  output logic              PCld,
  output logic              writeRegEn,
  output logic              writeRegSel,
  output logic              MemToReg,
  output logic              ALUSrcA,
  output logic [1:0]        PCSrc,
  output logic [1:0]        ALUSrcB,
  output logic [2:0]        ALU_control,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [3:0]        state_o
`ifdef MC_CU_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic       w_hit;
  logic       w_func_ok;
  logic [2:0] w_func_alu;
  logic       w_is_imm;
  logic       w_is_halt;

  assign w_is_imm  = (opc[OPC_W-1 -: 2] == OP_IMM_HI);
  assign w_is_halt = (&opc) && (&func);

  // R-type: exactly one function bit, and only the bits that name an operation.
  always_comb begin
    w_func_ok  = 1'b1;
    w_func_alu = ALU_PASSB;
    if (!$onehot(func))                     w_func_ok  = 1'b0;
    else if (func[FN_ADD])                  w_func_alu = ALU_ADD;
    else if (func[FN_SUB])                  w_func_alu = ALU_SUB;
    else if (func[FN_AND])                  w_func_alu = ALU_AND;
    else if (func[FN_OR])                   w_func_alu = ALU_OR;
    else if (func[FN_NOT])                  w_func_alu = ALU_NOT;
    else if (func[FN_MOV0] || func[FN_MOV1]) w_func_alu = ALU_PASSB;
    else                                    w_func_ok  = 1'b0;
  end

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_next != r_state),
    .i_inc (is_mem_wait(r_state) && !mem_ready),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IF;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCld        = 1'b0;
    writeRegEn  = 1'b0;
    writeRegSel = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 1'b0;
    PCSrc       = PC_ALU;
    ALUSrcB     = SRCB_REG;
    ALU_control = ALU_ADD;

    case (r_state)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          IRWrite     = 1'b1;
          PCld        = 1'b1;
          ALUSrcB     = SRCB_ONE;
          ALU_control = ALU_ADD;
          w_next      = S_ID;
        end else if (w_hit) begin
          w_next = S_ERR;
        end
      end
      S_ID: begin
        if (w_is_halt)                          w_next = S_HALT;
        else if (opc == OPC_W'(OP_LOAD))        w_next = S_MA;
        else if (opc == OPC_W'(OP_STORE))       w_next = S_MA;
        else if (opc == OPC_W'(OP_JUMP))        w_next = S_JMP;
        else if (opc == OPC_W'(OP_BRZ))         w_next = S_BR;
        else if (opc == OPC_W'(OP_RTYPE))       w_next = S_EXR;
        else if (w_is_imm)                      w_next = S_EXI;
        else                                    w_next = S_ERR;
      end
      S_EXR: begin
        ALU_control = w_func_ok ? w_func_alu : ALU_ADD;
        w_next      = w_func_ok ? S_WBR : S_ERR;
      end
      S_WBR: begin
        writeRegEn  = 1'b1;
        ALU_control = w_func_alu;
        w_next      = S_IF;
      end
      S_EXI: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_control = {1'b0, opc[1:0]};
        w_next      = S_WBI;
      end
      S_WBI: begin
        writeRegEn  = 1'b1;
        writeRegSel = 1'b1;
        w_next      = S_IF;
      end
      S_MA: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_control = ALU_ADD;
        w_next      = (opc == OPC_W'(OP_LOAD)) ? S_MR : S_MW;
      end
      S_MR: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready)  w_next = S_MWB;
        else if (w_hit) w_next = S_ERR;
      end
      S_MW: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready)  w_next = S_IF;
        else if (w_hit) w_next = S_ERR;
      end
      S_MWB: begin
        writeRegEn = 1'b1;
        MemToReg   = 1'b1;
        w_next     = S_IF;
      end
      S_JMP: begin
        PCld   = 1'b1;
        PCSrc  = PC_JUMP;
        w_next = S_IF;
      end
      S_BR: begin
        ALU_control = ALU_SUB;
        PCld        = zero;
        PCSrc       = PC_BRANCH;
        w_next      = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase

    // Reset parks the FSM in IF; keep the bus quiet until it is released.
    if (!rst) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCld        = 1'b0;
      writeRegEn  = 1'b0;
      writeRegSel = 1'b0;
      MemToReg    = 1'b0;
      ALUSrcA     = 1'b0;
      PCSrc       = PC_ALU;
      ALUSrcB     = SRCB_REG;
      ALU_control = ALU_ADD;
    end
  end

  assign busy    = (r_state != S_HALT) && (r_state != S_ERR);
  assign halted  = (r_state == S_HALT);
  assign err     = (r_state == S_ERR);
  assign state_o = r_state;

`ifdef MC_CU_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (busy) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if ((w_next == S_IF) && (r_state != S_IF)) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cyc_cnt   = r_cyc_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_control_unit_p.sv
// Directed bench for mc_control_unit_p (TIMEOUT=4): each task drives one
// scenario and compares outputs at the falling edge against hand-derived values.
module tb_mc_control_unit_p;
  import mc_cu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opc = '0;
  logic [8:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, IorD, IRWrite, PCld, writeRegEn;
  logic       writeRegSel, MemToReg, ALUSrcA;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALU_control;
  logic       busy, halted, err;
  logic [3:0] state_o;
`ifdef MC_CU_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mc_control_unit_p #(.OPC_W(4), .FUNC_W(9), .TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .IorD(IorD), .IRWrite(IRWrite),
    .PCld(PCld), .writeRegEn(writeRegEn), .writeRegSel(writeRegSel),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB),
    .ALU_control(ALU_control), .busy(busy), .halted(halted), .err(err),
    .state_o(state_o)
`ifdef MC_CU_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; opc = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2; rst = 1'b0; #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %0b exp 0", mem_read); end
    checks++; if (state_o !== S_IF) begin errors++; $display("FAIL rst_state: got %0d exp %0d", state_o, S_IF); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== S_IF) begin errors++; $display("FAIL rel_state: got %0d exp %0d", state_o, S_IF); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rel_err: got %0b exp 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rel_busy: got %0b exp 1", busy); end
    checks++; if (mem_read !== 1'b1 || IRWrite !== 1'b0) begin errors++; $display("FAIL rel_if_wait: mem_read=%0b IRWrite=%0b exp 1/0", mem_read, IRWrite); end
  endtask

  task automatic test_reset_mid_mr();
    do_reset();
    opc = OP_LOAD; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== S_MR || mem_read !== 1'b1) begin errors++; $display("FAIL mid_mr_pre: state=%0d mem_read=%0b exp %0d/1", state_o, mem_read, S_MR); end
    #1 rst = 1'b0; #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL mid_mr_drop: got %0b exp 0", mem_read); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== S_IF || err !== 1'b0) begin errors++; $display("FAIL mid_mr_release: state=%0d err=%0b exp %0d/0", state_o, err, S_IF); end
  endtask

  task automatic test_rtype();
    logic [8:0] fv [7] = '{9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h001, 9'h002};
    logic [2:0] av [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      opc = OP_RTYPE; func = fv[i]; mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (IRWrite !== 1'b1 || PCld !== 1'b1 || ALUSrcB !== 2'b01) begin errors++; $display("FAIL rt_if[%0d]: IRWrite=%0b PCld=%0b ALUSrcB=%0b exp 1/1/01", i, IRWrite, PCld, ALUSrcB); end
      tick();
      @(negedge clk);
      checks++; if (state_o !== S_ID) begin errors++; $display("FAIL rt_id[%0d]: got %0d exp %0d", i, state_o, S_ID); end
      tick();
      @(negedge clk);
      checks++; if (state_o !== S_EXR || writeRegEn !== 1'b0 || ALU_control !== av[i]) begin errors++; $display("FAIL rt_exr[%0d]: state=%0d wen=%0b alu=%0b exp %0d/0/%0b", i, state_o, writeRegEn, ALU_control, S_EXR, av[i]); end
      tick();
      @(negedge clk);
      checks++; if (state_o !== S_WBR || writeRegEn !== 1'b1 || writeRegSel !== 1'b0 || ALU_control !== av[i]) begin errors++; $display("FAIL rt_wbr[%0d]: state=%0d wen=%0b sel=%0b alu=%0b exp %0d/1/0/%0b", i, state_o, writeRegEn, writeRegSel, ALU_control, S_WBR, av[i]); end
      tick();
      @(negedge clk);
      checks++; if (state_o !== S_IF || writeRegEn !== 1'b0) begin errors++; $display("FAIL rt_back_if[%0d]: state=%0d wen=%0b exp %0d/0", i, state_o, writeRegEn, S_IF); end
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    opc = OP_LOAD; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_MA || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin errors++; $display("FAIL ld_ma: state=%0d srcA=%0b srcB=%0b exp %0d/1/10", state_o, ALUSrcA, ALUSrcB, S_MA); end
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (state_o !== S_MR || mem_read !== 1'b1 || IorD !== 1'b1) begin errors++; $display("FAIL ld_mr[%0d]: state=%0d mem_read=%0b IorD=%0b exp %0d/1/1", i, state_o, mem_read, IorD, S_MR); end
      tick();
    end
    @(negedge clk);
    checks++; if (state_o !== S_MWB || MemToReg !== 1'b1 || writeRegEn !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL ld_mwb: state=%0d m2r=%0b wen=%0b mem_read=%0b exp %0d/1/1/0", state_o, MemToReg, writeRegEn, mem_read, S_MWB); end
    tick();
    @(negedge clk);
    checks++; if (state_o !== S_IF) begin errors++; $display("FAIL ld_back_if: got %0d exp %0d", state_o, S_IF); end
  endtask

  task automatic test_store();
    do_reset();
    opc = OP_STORE; mem_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_MW || mem_write !== 1'b1 || mem_read !== 1'b0 || IorD !== 1'b1) begin errors++; $display("FAIL st_mw: state=%0d mem_write=%0b mem_read=%0b IorD=%0b exp %0d/1/0/1", state_o, mem_write, mem_read, IorD, S_MW); end
    tick();
    @(negedge clk);
    checks++; if (state_o !== S_IF) begin errors++; $display("FAIL st_back_if: got %0d exp %0d", state_o, S_IF); end
  endtask

  task automatic test_branch_jump();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      opc = OP_BRZ; zero = z[0]; mem_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      checks++; if (state_o !== S_BR || PCld !== z[0] || PCSrc !== 2'b10 || ALU_control !== 3'b001) begin errors++; $display("FAIL brz[z=%0d]: state=%0d PCld=%0b PCSrc=%0b alu=%0b exp %0d/%0b/10/001", z, state_o, PCld, PCSrc, ALU_control, S_BR, z[0]); end
      tick();
      @(negedge clk);
      checks++; if (state_o !== S_IF) begin errors++; $display("FAIL brz_back_if[z=%0d]: got %0d exp %0d", z, state_o, S_IF); end
    end
    do_reset();
    opc = OP_JUMP; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_JMP || PCld !== 1'b1 || PCSrc !== 2'b01) begin errors++; $display("FAIL jmp: state=%0d PCld=%0b PCSrc=%0b exp %0d/1/01", state_o, PCld, PCSrc, S_JMP); end
  endtask

  task automatic test_imm();
    do_reset();
    opc = 4'b1101; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_EXI || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALU_control !== 3'b001) begin errors++; $display("FAIL exi: state=%0d srcA=%0b srcB=%0b alu=%0b exp %0d/1/10/001", state_o, ALUSrcA, ALUSrcB, ALU_control, S_EXI); end
    tick();
    @(negedge clk);
    checks++; if (state_o !== S_WBI || writeRegEn !== 1'b1 || writeRegSel !== 1'b1) begin errors++; $display("FAIL wbi: state=%0d wen=%0b sel=%0b exp %0d/1/1", state_o, writeRegEn, writeRegSel, S_WBI); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (state_o !== S_IF || mem_read !== 1'b1) begin errors++; $display("FAIL to_wait[%0d]: state=%0d mem_read=%0b exp %0d/1", i, state_o, mem_read, S_IF); end
      tick();
    end
    @(negedge clk);
    checks++; if (state_o !== S_ERR || err !== 1'b1 || busy !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL to_err: state=%0d err=%0b busy=%0b mem_read=%0b exp %0d/1/0/0", state_o, err, busy, mem_read, S_ERR); end
    mem_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_ERR || err !== 1'b1) begin errors++; $display("FAIL to_sticky: state=%0d err=%0b exp %0d/1", state_o, err, S_ERR); end
    do_reset();
    @(negedge clk);
    checks++; if (state_o !== S_IF || err !== 1'b0) begin errors++; $display("FAIL to_clear: state=%0d err=%0b exp %0d/0", state_o, err, S_IF); end
    // Ready arriving on the TIMEOUT cycle completes the fetch.
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== S_IF || IRWrite !== 1'b1) begin errors++; $display("FAIL to_edge_fetch: state=%0d IRWrite=%0b exp %0d/1", state_o, IRWrite, S_IF); end
    tick();
    @(negedge clk);
    checks++; if (state_o !== S_ID || err !== 1'b0) begin errors++; $display("FAIL to_edge_id: state=%0d err=%0b exp %0d/0", state_o, err, S_ID); end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    opc = 4'b0011; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (state_o !== S_ID) begin errors++; $display("FAIL ill_opc_id: got %0d exp %0d", state_o, S_ID); end
    tick();
    @(negedge clk);
    checks++; if (state_o !== S_ERR || err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ill_opc_err: state=%0d err=%0b busy=%0b exp %0d/1/0", state_o, err, busy, S_ERR); end
    do_reset();
    opc = OP_RTYPE; func = 9'b000001100; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_EXR || err !== 1'b0) begin errors++; $display("FAIL ill_func_exr: state=%0d err=%0b exp %0d/0", state_o, err, S_EXR); end
    tick();
    @(negedge clk);
    checks++; if (state_o !== S_ERR || err !== 1'b1 || writeRegEn !== 1'b0) begin errors++; $display("FAIL ill_func_err: state=%0d err=%0b wen=%0b exp %0d/1/0", state_o, err, writeRegEn, S_ERR); end
    do_reset();
    opc = 4'b1111; func = 9'h1FF; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_HALT || halted !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL halt: state=%0d halted=%0b busy=%0b err=%0b mem_read=%0b exp %0d/1/0/0/0", state_o, halted, busy, err, mem_read, S_HALT); end
    tick(); tick();
    @(negedge clk);
    checks++; if (state_o !== S_HALT || halted !== 1'b1) begin errors++; $display("FAIL halt_hold: state=%0d halted=%0b exp %0d/1", state_o, halted, S_HALT); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mr();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch_jump();
    test_imm();
    test_timeout();
    test_illegal_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
